// File: rtl/tx_ep_arb.sv
// Round-robin owner of the shared TRN tx endpoint; muxes the owner's tx bus and owns the tag counter.
// Latency: grant one cycle after IDLE sees req; TRN mux is combinational with no added latency.
// Backpressure: a grant is held until drv_ep or GRANT_TO. With TX_TAG_LIMIT_EN, req_0 is masked at 32 outstanding tags.
module tx_ep_arb #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned GRANT_TO   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic        req_1,
    output logic        my_trn_0,
    output logic        my_trn_1,
    input  logic        drv_ep_0,
    input  logic        drv_ep_1,
    input  logic        tag_inc_0,
    input  logic        tag_inc_1,
    output logic [4:0]  tag_trn,
    input  logic [63:0] trn_td_0,
    input  logic [63:0] trn_td_1,
    input  logic [7:0]  trn_trem_n_0,
    input  logic [7:0]  trn_trem_n_1,
    input  logic        trn_tsof_n_0,
    input  logic        trn_tsof_n_1,
    input  logic        trn_teof_n_0,
    input  logic        trn_teof_n_1,
    input  logic        trn_tsrc_rdy_n_0,
    input  logic        trn_tsrc_rdy_n_1,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
`ifdef TX_TAG_LIMIT_EN
    input  logic        tag_rls,
`endif
    output logic        arb_err
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;

    state_t     state, state_nxt, rel_state;
    logic       owner, owner_nxt;
    logic       last, last_nxt;
    logic [7:0] to_cnt;
    logic [3:0] gap_cnt;
    logic       granted, owner_drv, both_drv, mux_en, inc_ok, err;
    logic       req0_eff;

`ifdef TX_TAG_LIMIT_EN
    logic [5:0] outstanding;
    logic       rls_ok;
    assign req0_eff = req_0 && (outstanding < 6'd32);
    assign rls_ok   = tag_rls && (outstanding != 6'd0);
`else
    assign req0_eff = req_0;
`endif

    assign granted   = (state == GRANT) || (state == BUSY);
    assign my_trn_0  = granted && !owner;
    assign my_trn_1  = granted && owner;
    assign owner_drv = owner ? drv_ep_1 : drv_ep_0;
    assign both_drv  = drv_ep_0 && drv_ep_1;
    assign mux_en    = granted && owner_drv && !both_drv;
    assign inc_ok    = granted && (owner ? tag_inc_1 : tag_inc_0);
    assign rel_state = (GAP_CYCLES == 0) ? IDLE : GAP;

    always_comb begin
        err = (tag_inc_0 && !my_trn_0) || (tag_inc_1 && !my_trn_1) ||
              (drv_ep_0 && !my_trn_0) || (drv_ep_1 && !my_trn_1) || both_drv;
`ifdef TX_TAG_LIMIT_EN
        // A release that cancels a same-cycle increment is not an underflow.
        if (tag_rls && (outstanding == 6'd0) && !inc_ok)
            err = 1'b1;
`endif
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0_eff && req_1) begin
                    owner_nxt = ~last;
                    state_nxt = GRANT;
                end else if (req0_eff) begin
                    owner_nxt = 1'b0;
                    state_nxt = GRANT;
                end else if (req_1) begin
                    owner_nxt = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (owner_drv) begin
                    state_nxt = BUSY;
                end else if ((GRANT_TO != 0) && (to_cnt == 8'(GRANT_TO - 1))) begin
                    last_nxt  = owner;
                    state_nxt = rel_state;
                end
            end
            BUSY: begin
                if (!owner_drv) begin
                    last_nxt  = owner;
                    state_nxt = rel_state;
                end
            end
            GAP: begin
                if (gap_cnt == 4'(GAP_CYCLES - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            to_cnt  <= 8'd0;
            gap_cnt <= 4'd0;
            tag_trn <= 5'd0;
            arb_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
            to_cnt  <= (state == GRANT) ? to_cnt + 8'd1 : 8'd0;
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (inc_ok)
                tag_trn <= tag_trn + 5'd1;
            arb_err <= err;
        end
    end

`ifdef TX_TAG_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst)
            outstanding <= 6'd0;
        else if (inc_ok && !tag_rls && (outstanding != 6'd63))
            outstanding <= outstanding + 6'd1;
        else if (rls_ok && !inc_ok)
            outstanding <= outstanding - 6'd1;
    end
`endif

    always_comb begin
        trn_td         = 64'd0;
        trn_trem_n     = 8'hFF;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        if (mux_en) begin
            trn_td         = owner ? trn_td_1 : trn_td_0;
            trn_trem_n     = owner ? trn_trem_n_1 : trn_trem_n_0;
            trn_tsof_n     = owner ? trn_tsof_n_1 : trn_tsof_n_0;
            trn_teof_n     = owner ? trn_teof_n_1 : trn_teof_n_0;
            trn_tsrc_rdy_n = owner ? trn_tsrc_rdy_n_1 : trn_tsrc_rdy_n_0;
        end
    end

endmodule
